unified_buffer_dp: RTL and testbench

Simple-dual-port unified buffer for activations and partial results, with lane-granular write masking and a selectable read pipeline depth. One write port and one read port operate in the same cycle. A built-in clear sequencer zeroes the whole array after reset or on request. It sits between the input DMA / accumulator writeback and the systolic-array feeder.

---
 rtl/unified_buffer_if.sv | 30 +++
 rtl/unified_buffer_dp.sv | 144 ++++++++++++++
 tb/tb_unified_buffer_dp.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/unified_buffer_if.sv
// Bundle of the unified buffer's command and read-return signals.
// The master side (DMA / writeback / feeder) drives the strobes; the buffer is the slave.
interface unified_buffer_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int LANES       = 8,
  parameter int LANEWIDTH   = 8
);
  localparam int WORDSIZE = LANES * LANEWIDTH;

  logic                   clear_req;
  logic                   ready;
  logic                   wr_en;
  logic [ADDRESSSIZE-1:0] wr_addr;
  logic [LANES-1:0]       wr_mask;
  logic [WORDSIZE-1:0]    wr_data;
  logic                   rd_en;
  logic [ADDRESSSIZE-1:0] rd_addr;
  logic [WORDSIZE-1:0]    rd_data;
  logic                   rd_valid;

  modport master (
    output clear_req, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr,
    input  ready, rd_data, rd_valid
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr,
    output ready, rd_data, rd_valid
  );
endinterface

// File: rtl/unified_buffer_dp.sv
// Simple-dual-port unified buffer: lane-masked writes, write-first same-address
// bypass, 1- or 2-cycle read pipeline and a zero-fill sweep after reset / on request.
module unified_buffer_dp #(
  parameter int ADDRESSSIZE  = 10,
  parameter int LANES        = 8,
  parameter int LANEWIDTH    = 8,
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  unified_buffer_if.slave  bus
);

  localparam int WORDSIZE = LANES * LANEWIDTH;
  localparam int DEPTH    = 1 << ADDRESSSIZE;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // Lane-wise select: lanes with sel set come from a, the rest from b.
  function automatic logic [WORDSIZE-1:0] lane_merge(
    input logic [WORDSIZE-1:0] a,
    input logic [WORDSIZE-1:0] b,
    input logic [LANES-1:0]    sel
  );
    logic [WORDSIZE-1:0] r;
    r = b;
    for (int l = 0; l < LANES; l++) begin
      if (sel[l]) r[l*LANEWIDTH +: LANEWIDTH] = a[l*LANEWIDTH +: LANEWIDTH];
    end
    return r;
  endfunction

  logic [0:0]             state;
  logic [ADDRESSSIZE-1:0] cnt;
  logic                   ready;
  logic                   wr_fire;
  logic                   rd_fire;

  logic                   ram_we;
  logic [ADDRESSSIZE-1:0] ram_waddr;
  logic [LANES-1:0]       ram_wmask;
  logic [WORDSIZE-1:0]    ram_wdata;

  logic [WORDSIZE-1:0]    mem [0:DEPTH-1];
  logic [WORDSIZE-1:0]    mem_q_p0;
  logic [WORDSIZE-1:0]    byp_data_p0;
  logic [LANES-1:0]       byp_mask_p0;
  logic                   vld_p0;
  logic [WORDSIZE-1:0]    merged_p0;

  assign ready   = (state == ST_IDLE);
  assign wr_fire = ready & bus.wr_en;
  assign rd_fire = ready & bus.rd_en;

  // During the sweep the write port is borrowed to zero mem[cnt] across all lanes.
  always_comb begin
    ram_we    = wr_fire;
    ram_waddr = bus.wr_addr;
    ram_wmask = bus.wr_mask;
    ram_wdata = bus.wr_data;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cnt;
      ram_wmask = '1;
      ram_wdata = '0;
    end
  end

  // Clear sequencer: sweep counter terminates on all-ones, no extra counter bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= ST_IDLE;
        end
        default: begin
          if (bus.clear_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Block RAM: per-lane write enables, registered read of the pre-write contents.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (ram_we && ram_wmask[l])
        mem[ram_waddr][l*LANEWIDTH +: LANEWIDTH] <= ram_wdata[l*LANEWIDTH +: LANEWIDTH];
    end
    if (rd_fire) mem_q_p0 <= mem[bus.rd_addr];
  end

  // Stage p0: capture the same-address write for the write-first bypass.
  // Reset loads an all-lanes bypass of zero so rd_data reads 0 without resetting the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_mask_p0 <= '1;
      byp_data_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) begin
        byp_mask_p0 <= (wr_fire && (bus.wr_addr == bus.rd_addr)) ? bus.wr_mask : '0;
        byp_data_p0 <= bus.wr_data;
      end
    end
  end

  assign merged_p0 = lane_merge(byp_data_p0, mem_q_p0, byp_mask_p0);

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [WORDSIZE-1:0] out_p1;
      logic                vld_p1;

      // Stage p1: optional output register; holds the last word between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_p1 <= '0;
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) out_p1 <= merged_p0;
        end
      end

      assign bus.rd_data  = out_p1;
      assign bus.rd_valid = vld_p1;
    end else begin : g_lat1
      assign bus.rd_data  = merged_p0;
      assign bus.rd_valid = vld_p0;
    end
  endgenerate

  assign bus.ready = ready;

endmodule

// File: tb/tb_unified_buffer_dp.sv
// Bench for unified_buffer_dp: one latency-1 and one latency-2 instance share
// identical stimulus; an array-based model predicts every cycle of both.
module tb_unified_buffer_dp;

  localparam int AW = 4;
  localparam int NL = 8;
  localparam int LW = 8;
  localparam int WS = NL * LW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NL-1:0] wr_mask;
  logic [WS-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unified_buffer_if #(.ADDRESSSIZE(AW), .LANES(NL), .LANEWIDTH(LW)) ub1 ();
  unified_buffer_if #(.ADDRESSSIZE(AW), .LANES(NL), .LANEWIDTH(LW)) ub2 ();

  assign ub1.clear_req = clear_req;
  assign ub1.wr_en     = wr_en;
  assign ub1.wr_addr   = wr_addr;
  assign ub1.wr_mask   = wr_mask;
  assign ub1.wr_data   = wr_data;
  assign ub1.rd_en     = rd_en;
  assign ub1.rd_addr   = rd_addr;
  assign ub2.clear_req = clear_req;
  assign ub2.wr_en     = wr_en;
  assign ub2.wr_addr   = wr_addr;
  assign ub2.wr_mask   = wr_mask;
  assign ub2.wr_data   = wr_data;
  assign ub2.rd_en     = rd_en;
  assign ub2.rd_addr   = rd_addr;

  unified_buffer_dp #(.ADDRESSSIZE(AW), .LANES(NL), .LANEWIDTH(LW), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(ub1.slave)
  );
  unified_buffer_dp #(.ADDRESSSIZE(AW), .LANES(NL), .LANEWIDTH(LW), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(ub2.slave)
  );

  task automatic chk(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory array, ready flag, sweep cycles remaining,
  // and the list of read results ordered by accepting edge.
  logic [WS-1:0] m_mem [DEPTH];
  logic          m_ready;
  int            clr_left;
  logic          prev_v;
  logic [WS-1:0] prev_d;
  logic [WS-1:0] last1, last2;
  logic          e_ready, e_v1, e_v2;
  logic [WS-1:0] e_d1, e_d2;

  task automatic model_step();
    logic          cur_v;
    logic [WS-1:0] cur_d;
    logic [WS-1:0] w;
    cur_v = 1'b0;
    cur_d = '0;
    if (rst) begin
      m_ready = 1'b0; clr_left = DEPTH;
      prev_v = 1'b0; prev_d = '0; last1 = '0; last2 = '0;
      e_ready = 1'b0; e_v1 = 1'b0; e_v2 = 1'b0; e_d1 = '0; e_d2 = '0;
      return;
    end
    if (!m_ready) begin
      clr_left--;
      if (clr_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ready = 1'b1;
      end
    end else begin
      w = m_mem[wr_addr];
      for (int l = 0; l < NL; l++)
        if (wr_mask[l]) w[l*LW +: LW] = wr_data[l*LW +: LW];
      if (rd_en) begin
        cur_v = 1'b1;
        cur_d = (wr_en && wr_addr == rd_addr) ? w : m_mem[rd_addr];
      end
      if (wr_en) m_mem[wr_addr] = w;
      if (clear_req) begin
        m_ready = 1'b0; clr_left = DEPTH;
      end
    end
    e_ready = m_ready;
    e_v1 = cur_v;
    if (cur_v) last1 = cur_d;
    e_d1 = last1;
    e_v2 = prev_v;
    if (prev_v) last2 = prev_d;
    e_d2 = last2;
    prev_v = cur_v;
    prev_d = cur_d;
  endtask

  // Advance one clock with the currently driven inputs and compare both instances.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("ready_l1", {63'd0, ub1.ready}, {63'd0, e_ready});
    chk("ready_l2", {63'd0, ub2.ready}, {63'd0, e_ready});
    chk("valid_l1", {63'd0, ub1.rd_valid}, {63'd0, e_v1});
    chk("valid_l2", {63'd0, ub2.rd_valid}, {63'd0, e_v2});
    chk("data_l1", ub1.rd_data, e_d1);
    chk("data_l2", ub2.rd_data, e_d2);
  endtask

  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [NL-1:0] wm,
                     input logic [WS-1:0] wd, input logic re, input logic [AW-1:0] ra,
                     input logic clr);
    wr_en = we; wr_addr = wa; wr_mask = wm; wr_data = wd;
    rd_en = re; rd_addr = ra; clear_req = clr;
    tick();
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic rand_cyc(input int clr_pct);
    cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)), NL'($urandom),
        {$urandom, $urandom}, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)),
        1'($urandom_range(0, 99) < clr_pct));
  endtask

  int n;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ready = 1'b0; clr_left = DEPTH;
    prev_v = 1'b0; prev_d = '0; last1 = '0; last2 = '0;
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;

    // Power-up sweep length
    n = 0;
    while (!ub1.ready && n < 100) begin idle(); n++; end
    chk("sweep_len_reset", 64'(n), 64'd16);

    // Read of a cleared word, latency 1 then latency 2
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
    chk("t1_valid_l1", {63'd0, ub1.rd_valid}, 64'd1);
    chk("t1_data_l1", ub1.rd_data, 64'd0);
    idle();
    chk("t1_valid_l2", {63'd0, ub2.rd_valid}, 64'd1);
    chk("t1_data_l2", ub2.rd_data, 64'd0);

    // Lane masking
    cyc(1'b1, 4'd3, 8'hFF, 64'h0102030405060708, 1'b0, '0, 1'b0);
    cyc(1'b1, 4'd3, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    chk("t2_masked", ub1.rd_data, 64'h01020304FFFFFFFF);

    // Same-cycle read/write, same and different address
    cyc(1'b1, 4'd7, 8'hFF, 64'h0, 1'b0, '0, 1'b0);
    cyc(1'b1, 4'd8, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 1'b0, '0, 1'b0);
    cyc(1'b1, 4'd7, 8'hF0, 64'h1111111111111111, 1'b1, 4'd7, 1'b0);
    chk("t3_write_first", ub1.rd_data, 64'h1111111100000000);
    cyc(1'b1, 4'd7, 8'hF0, 64'h1111111111111111, 1'b1, 4'd8, 1'b0);
    chk("t3_other_addr", ub1.rd_data, 64'hAAAAAAAAAAAAAAAA);
    idle();

    // Back-to-back reads through the latency-2 pipeline
    for (int i = 0; i < 4; i++) cyc(1'b1, AW'(i), 8'hFF, 64'(10 + i), 1'b0, '0, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      cyc(1'b0, '0, '0, '0, (t <= 4), AW'(t - 1), 1'b0);
      chk("t4_valid_l2", {63'd0, ub2.rd_valid}, {63'd0, (t >= 2 && t <= 5)});
      if (t >= 2 && t <= 5) chk("t4_data_l2", ub2.rd_data, 64'(10 + t - 2));
    end

    // Clear request together with a write and read of address 2
    cyc(1'b1, 4'd2, 8'hFF, 64'h5555555555555555, 1'b1, 4'd2, 1'b1);
    chk("t5_pre_clear_read", ub1.rd_data, 64'h5555555555555555);
    n = 0;
    while (!ub1.ready && n < 100) begin
      rand_cyc(50);
      chk("t5_no_valid_in_sweep", {63'd0, ub1.rd_valid}, 64'd0);
      n++;
    end
    chk("sweep_len_clear", 64'(n), 64'd16);
    for (int a = 0; a < DEPTH; a++) begin
      cyc(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
      chk("t5_zeroed", ub1.rd_data, 64'd0);
    end
    idle();

    // Reset in the middle of a sweep restarts it from address 0
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    repeat (5) idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    n = 0;
    while (!ub1.ready && n < 100) begin idle(); n++; end
    chk("sweep_len_midreset", 64'(n), 64'd16);

    // Randomized traffic with occasional clear requests
    repeat (400) rand_cyc(2);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
